// File: rtl/unary_root_stream.sv
// Unary R-th root (R = 2 or 3): one N-bit unary frame in, one N-bit unary frame out with exactly T ones.
// Latency: output bits are emitted as soon as the lo/hi root trackers bound them; the frame ends on the Nth output handshake.
// Backpressure: y/out_valid hold while out_ready is low; the input side keeps accepting until N bits are taken.
module unary_root_stream #(
  parameter int STREAM_LEN  = 32,
  parameter int ROOT_ORDER  = 2,
  parameter int COUNT_WIDTH = $clog2(STREAM_LEN + 1),
  parameter int PROD_WIDTH  = ROOT_ORDER * COUNT_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   a,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   y,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] root_count
);

  // Only square and cube roots are supported; anything else stops elaboration.
  if ((ROOT_ORDER != 2) && (ROOT_ORDER != 3)) begin : g_bad_root_order
    $error("unary_root_stream: ROOT_ORDER must be 2 or 3");
  end
  if (STREAM_LEN < 2) begin : g_bad_stream_len
    $error("unary_root_stream: STREAM_LEN must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // K is compared against t^R in the scaled domain K * N^(R-1).
  localparam logic [PROD_WIDTH-1:0]  SCALE = (ROOT_ORDER == 3) ?
                                             PROD_WIDTH'(STREAM_LEN * STREAM_LEN) :
                                             PROD_WIDTH'(STREAM_LEN);
  localparam logic [COUNT_WIDTH-1:0] N_C   = COUNT_WIDTH'(STREAM_LEN);

  // x^R at full product width; operands never exceed N+1 so nothing overflows.
  function automatic logic [PROD_WIDTH-1:0] pow_r(input logic [PROD_WIDTH-1:0] x);
    logic [PROD_WIDTH-1:0] sq;
    sq = x * x;
    if (ROOT_ORDER == 3) return sq * x;
    else return sq;
  endfunction

  state_t                 r_state;
  logic [COUNT_WIDTH-1:0] r_k_ones;
  logic [COUNT_WIDTH-1:0] r_in_cnt;
  logic [COUNT_WIDTH-1:0] r_y_ones;
  logic [COUNT_WIDTH-1:0] r_y_cnt;
  logic [COUNT_WIDTH-1:0] r_lo_root;
  logic [COUNT_WIDTH-1:0] r_hi_root;
  logic                   r_y;
  logic                   r_out_valid;
  logic                   r_done;
  logic [COUNT_WIDTH-1:0] r_root_count;

  logic [COUNT_WIDTH-1:0] w_k_hi;
  logic                   w_lo_step;
  logic                   w_hi_step;
  logic                   w_slot_free;
  logic [COUNT_WIDTH-1:0] w_y_zeros;
  logic                   w_can_emit;
  logic                   w_emit_one;
  logic                   w_emit_zero;
  logic                   w_last_hs;
  logic                   w_in_fire;

  // Upper bound on the final K: every bit still to come could be a one.
  assign w_k_hi      = r_k_ones + (N_C - r_in_cnt);

  // Trackers move at most one step per cycle toward T, using the registered K bounds.
  assign w_lo_step   = (r_lo_root < N_C) &&
                       (pow_r(PROD_WIDTH'(r_lo_root) + PROD_WIDTH'(1)) <= (PROD_WIDTH'(r_k_ones) * SCALE));
  assign w_hi_step   = (r_hi_root != '0) &&
                       (pow_r(PROD_WIDTH'(r_hi_root)) > (PROD_WIDTH'(w_k_hi) * SCALE));

  // A one is safe while ones < lo_root; a zero is safe while zeros < N - hi_root.
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_y_zeros   = r_y_cnt - r_y_ones;
  assign w_can_emit  = w_slot_free && (r_y_cnt < N_C);
  assign w_emit_one  = w_can_emit && (r_y_ones < r_lo_root);
  assign w_emit_zero = w_can_emit && !w_emit_one && (w_y_zeros < (N_C - r_hi_root));

  // The Nth bit was counted at emission, so its handshake closes the frame.
  assign w_last_hs   = r_out_valid && out_ready && (r_y_cnt == N_C);
  assign w_in_fire   = in_valid && in_ready;

  assign in_ready    = (r_state == S_RUN) && (r_in_cnt < N_C);
  assign busy        = (r_state == S_RUN);
  assign out_valid   = r_out_valid;
  assign y           = r_y;
  assign done        = r_done;
  assign root_count  = r_root_count;

  // Frame FSM with input counting, root trackers and the registered output slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_k_ones     <= '0;
      r_in_cnt     <= '0;
      r_y_ones     <= '0;
      r_y_cnt      <= '0;
      r_lo_root    <= '0;
      r_hi_root    <= '0;
      r_y          <= 1'b0;
      r_out_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_root_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_k_ones  <= '0;
            r_in_cnt  <= '0;
            r_y_ones  <= '0;
            r_y_cnt   <= '0;
            r_lo_root <= '0;
            r_hi_root <= N_C;
          end
        end

        S_RUN: begin
          if (w_in_fire) begin
            r_k_ones <= r_k_ones + COUNT_WIDTH'(a);
            r_in_cnt <= r_in_cnt + COUNT_WIDTH'(1);
          end
          if (w_lo_step) r_lo_root <= r_lo_root + COUNT_WIDTH'(1);
          if (w_hi_step) r_hi_root <= r_hi_root - COUNT_WIDTH'(1);

          if (w_last_hs) begin
            r_state      <= S_DONE;
            r_out_valid  <= 1'b0;
            r_y          <= 1'b0;
            r_root_count <= r_y_ones;
            r_done       <= 1'b1;
          end else if (w_emit_one) begin
            r_y         <= 1'b1;
            r_out_valid <= 1'b1;
            r_y_ones    <= r_y_ones + COUNT_WIDTH'(1);
            r_y_cnt     <= r_y_cnt + COUNT_WIDTH'(1);
          end else if (w_emit_zero) begin
            r_y         <= 1'b0;
            r_out_valid <= 1'b1;
            r_y_cnt     <= r_y_cnt + COUNT_WIDTH'(1);
          end else if (w_slot_free) begin
            r_out_valid <= 1'b0;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unary_root_stream.sv
// Bench for unary_root_stream: an N=32/R=2 instance and an N=8/R=3 instance on shared stimulus.
// Expected root counts are queued at frame start and checked against observed ones and root_count at done.
// Output backpressure is driven randomly or as a fixed hold window; held y/out_valid are checked each stall cycle.
module tb_unary_root_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_d;
  logic in_valid;
  logic a;
  logic out_ready;
  logic sel;

  logic start_32, start_8;
  assign start_32 = start_d && !sel;
  assign start_8  = start_d && sel;

  logic       in_ready_32, out_valid_32, y_32, busy_32, done_32;
  logic [5:0] root_count_32;
  logic       in_ready_8, out_valid_8, y_8, busy_8, done_8;
  logic [3:0] root_count_8;

  unary_root_stream #(.STREAM_LEN(32), .ROOT_ORDER(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start_32),
    .in_valid  (in_valid),
    .in_ready  (in_ready_32),
    .a         (a),
    .out_valid (out_valid_32),
    .out_ready (out_ready),
    .y         (y_32),
    .busy      (busy_32),
    .done      (done_32),
    .root_count(root_count_32)
  );

  unary_root_stream #(.STREAM_LEN(8), .ROOT_ORDER(3)) dut_cube (
    .clk       (clk),
    .reset     (reset),
    .start     (start_8),
    .in_valid  (in_valid),
    .in_ready  (in_ready_8),
    .a         (a),
    .out_valid (out_valid_8),
    .out_ready (out_ready),
    .y         (y_8),
    .busy      (busy_8),
    .done      (done_8),
    .root_count(root_count_8)
  );

  logic        in_ready_s, out_valid_s, y_s, busy_s, done_s;
  logic [31:0] rc_s;
  assign in_ready_s  = sel ? in_ready_8  : in_ready_32;
  assign out_valid_s = sel ? out_valid_8 : out_valid_32;
  assign y_s         = sel ? y_8         : y_32;
  assign busy_s      = sel ? busy_8      : busy_32;
  assign done_s      = sel ? done_8      : done_32;
  assign rc_s        = sel ? 32'(root_count_8) : 32'(root_count_32);

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ipow(input int x, input int r);
    int p = 1;
    for (int i = 0; i < r; i++) p = p * x;
    return p;
  endfunction

  // Largest t with t^r <= k * n^(r-1).
  function automatic int root_model(input int k, input int n, input int r);
    int lim = k * ipow(n, r - 1);
    int t = 0;
    while (ipow(t + 1, r) <= lim) t++;
    return t;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"},   in_ready_s,  0);
    chk({tag, "_out_valid"},  out_valid_s, 0);
    chk({tag, "_y"},          y_s,         0);
    chk({tag, "_busy"},       busy_s,      0);
    chk({tag, "_done"},       done_s,      0);
    chk({tag, "_root_count"}, rc_s,        0);
  endtask

  // Runs one frame. Called and returns at a negedge. abort_at >= 0 returns once that many input bits are accepted.
  task automatic run_frame(input bit s, input int k, input int gap_pct, input bit rnd_rdy,
                           input int bp_cycles, input bit poke_start, input int abort_at);
    int n = s ? 8 : 32;
    int r = s ? 3 : 2;
    bit bits[32];
    int in_idx = 0, hs = 0, ones = 0, bp_left = 0, cyc = 0, expv;
    bit bp_used = 0, prev_stall = 0, prev_y = 0, finished = 0;

    for (int i = 0; i < 32; i++) bits[i] = (i < k);
    for (int i = n - 1; i > 0; i--) begin
      int j = $urandom_range(i);
      bit t = bits[i];
      bits[i] = bits[j];
      bits[j] = t;
    end

    sel = s;
    exp_q.push_back(root_model(k, n, r));
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    chk("busy_after_start", busy_s, 1);

    while (!finished && cyc < 3000) begin
      if (prev_stall) begin
        chk("stall_hold_valid", out_valid_s, 1);
        chk("stall_hold_y", y_s, prev_y);
      end
      if (done_s) begin
        finished = 1;
      end else if (abort_at >= 0 && in_idx == abort_at) begin
        in_valid = 1'b0;
        return;
      end else begin
        in_valid = (in_idx < n) && ($urandom_range(99) >= gap_pct);
        a        = in_valid ? bits[in_idx] : 1'b0;
        if (in_valid && in_ready_s) in_idx++;

        start_d = poke_start && (cyc == 6);

        if (bp_cycles > 0 && !bp_used && hs == n / 2) begin
          bp_left = bp_cycles;
          bp_used = 1;
        end
        if (bp_left > 0) begin
          out_ready = 1'b0;
          bp_left--;
        end else begin
          out_ready = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
        end

        if (out_valid_s && out_ready) begin
          hs++;
          ones += int'(y_s);
        end
        prev_stall = out_valid_s && !out_ready;
        prev_y     = y_s;
        cyc++;
        @(negedge clk);
      end
    end

    in_valid  = 1'b0;
    start_d   = 1'b0;
    out_ready = 1'b1;
    expv = exp_q.pop_front();
    if (!finished) begin
      chk("frame_timeout", 0, 1);
      return;
    end
    chk("ones_count", ones, expv);
    chk("root_count", rc_s, expv);
    chk("handshakes", hs, n);
    chk("out_valid_at_done", out_valid_s, 0);
    @(negedge clk);
    chk("done_one_cycle", done_s, 0);
    chk("idle_after_done", busy_s, 0);
    chk("root_count_held", rc_s, expv);
  endtask

  initial begin
    reset     = 1'b0;
    start_d   = 1'b0;
    in_valid  = 1'b0;
    a         = 1'b0;
    out_ready = 1'b1;
    sel       = 1'b0;
    #12;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_frame(0, 0,  0,  0, 0,  0, -1);   // all zeros in -> T=0
    run_frame(0, 32, 0,  0, 0,  0, -1);   // all ones in -> T=32
    run_frame(0, 8,  40, 1, 0,  0, -1);   // 8*32=256 -> 16
    run_frame(0, 2,  30, 1, 0,  0, -1);   // 64 -> 8
    run_frame(1, 1,  20, 1, 0,  0, -1);   // cube, 1*64 -> 4
    run_frame(1, 3,  20, 1, 0,  0, -1);   // cube, 192 -> 5
    run_frame(0, 8,  20, 0, 10, 0, -1);   // 10-cycle output hold mid-frame
    run_frame(0, 20, 25, 1, 0,  1, -1);   // start pulsed while busy; 640 -> 25

    // Abort a frame after 12 accepted inputs with an asynchronous reset.
    run_frame(0, 18, 20, 1, 0,  0, 12);
    void'(exp_q.pop_back());
    #2 reset = 1'b0;
    #1;
    check_reset_state("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_frame(0, 18, 20, 1, 0,  0, -1);   // 576 -> 24

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
